// File: rtl/edge_event_capture.sv
// edge_event_capture
//   Multi-channel edge detector. Each channel runs its raw input through a
//   persistence (glitch) filter and then detects rising and falling edges of
//   the filtered level, as selected by a runtime mode. For each channel it
//   provides a one-cycle pulse, the polarity of the last pulse, a sticky flag
//   and a saturating event counter. A lowest-index encoder summarises the
//   pulses of all channels.
//
// Parameters
//   N        number of channels (>=1)
//   FILT_LEN clock edges a changed input must persist before filt flips (>=1)
//   CW       per-channel event counter width (>=1)
//   INIT     reset value of the filtered level, applied to every channel (0/1)
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   in         [N]    raw channel inputs, already synchronous to clk
//   mode       [2N]   per channel {fall_en, rise_en}: 00 off, 01 rise, 10 fall, 11 both
//   clr        [N]    per-channel clear of sticky and cnt
//   filt       [N]    filtered level
//   pulse      [N]    one-cycle event strobe
//   pulse_dir  [N]    polarity of the most recent pulse (1 rising, 0 falling)
//   sticky     [N]    set by pulse, cleared by clr
//   cnt        [N*CW] saturating event counters, channel i at [i*CW +: CW]
//   evt_valid         OR of pulse
//   evt_idx    [IW]   lowest index with pulse set, 0 when evt_valid is 0
module edge_event_capture #(
  parameter int N        = 4,
  parameter int FILT_LEN = 1,
  parameter int CW       = 8,
  parameter int INIT     = 0,
  localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in,
  input  logic [2*N-1:0]  mode,
  input  logic [N-1:0]    clr,
  output logic [N-1:0]    filt,
  output logic [N-1:0]    pulse,
  output logic [N-1:0]    pulse_dir,
  output logic [N-1:0]    sticky,
  output logic [N*CW-1:0] cnt,
  output logic            evt_valid,
  output logic [IW-1:0]   evt_idx
);

  localparam int RW = $clog2(FILT_LEN + 1);
  localparam logic INIT_LVL = (INIT != 0);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi = gi + 1) begin : g_chan
      logic [RW-1:0] run_reg;
      logic          filt_reg;
      logic          pulse_reg;
      logic          dir_reg;
      logic          sticky_reg;
      logic [CW-1:0] cnt_reg;

      logic mismatch;
      logic flip;
      logic rise;
      logic fall;
      logic evt;

      // The filtered level flips on the edge where the run of mismatching
      // samples would reach FILT_LEN; with FILT_LEN=1 that is every mismatch.
      assign mismatch = (in[gi] != filt_reg);
      assign flip     = mismatch && (run_reg == RW'(FILT_LEN - 1));
      assign rise     = flip && in[gi];
      assign fall     = flip && !in[gi];
      // Mode is sampled on the flip edge itself; a disabled flip is dropped.
      assign evt      = (rise && mode[2*gi]) || (fall && mode[2*gi+1]);

      always_ff @(posedge clk) begin
        if (rst) begin
          run_reg    <= '0;
          filt_reg   <= INIT_LVL;
          pulse_reg  <= 1'b0;
          dir_reg    <= 1'b0;
          sticky_reg <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          if (!mismatch || flip) begin
            run_reg <= '0;
          end else begin
            run_reg <= run_reg + RW'(1);
          end

          if (flip) begin
            filt_reg <= in[gi];
          end

          // Registered together with filt so the pulse lines up with the
          // first cycle the new level is visible.
          pulse_reg <= evt;

          if (evt) begin
            dir_reg <= rise;
          end

          // An event on the same edge as clr counts from a cleared state.
          if (evt) begin
            sticky_reg <= 1'b1;
            if (clr[gi]) begin
              cnt_reg <= CW'(1);
            end else if (cnt_reg != {CW{1'b1}}) begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end else if (clr[gi]) begin
            sticky_reg <= 1'b0;
            cnt_reg    <= '0;
          end
        end
      end

      assign filt[gi]            = filt_reg;
      assign pulse[gi]           = pulse_reg;
      assign pulse_dir[gi]       = dir_reg;
      assign sticky[gi]          = sticky_reg;
      assign cnt[gi*CW +: CW]    = cnt_reg;
    end
  endgenerate

  // Priority encoder: scanning from the top down leaves the lowest set index.
  always_comb begin
    evt_valid = |pulse;
    evt_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pulse[i]) begin
        evt_idx = IW'(i);
      end
    end
  end

endmodule

// File: tb/tb_edge_event_capture.sv
// tb_edge_event_capture
//   Directed bench for edge_event_capture using four instances:
//     a: FILT_LEN=1, CW=2, INIT=0  (basic pulse, saturation, clr, encoder)
//     b: FILT_LEN=3, CW=8, INIT=0  (glitch rejection and latency)
//     c: FILT_LEN=4, CW=4, INIT=0  (reset discarding a partial run)
//     d: FILT_LEN=2, CW=4, INIT=1  (falling event from INIT=1)
module tb_edge_event_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic c_rst;

  // instance a
  logic [3:0] a_in, a_clr, a_filt, a_pulse, a_dir, a_sticky;
  logic [7:0] a_mode, a_cnt;
  logic       a_ev;
  logic [1:0] a_idx;
  // instance b
  logic [3:0]  b_in, b_clr, b_filt, b_pulse, b_dir, b_sticky;
  logic [7:0]  b_mode;
  logic [31:0] b_cnt;
  logic        b_ev;
  logic [1:0]  b_idx;
  // instance c
  logic [3:0]  c_in, c_clr, c_filt, c_pulse, c_dir, c_sticky;
  logic [7:0]  c_mode;
  logic [15:0] c_cnt;
  logic        c_ev;
  logic [1:0]  c_idx;
  // instance d
  logic [3:0]  d_in, d_clr, d_filt, d_pulse, d_dir, d_sticky;
  logic [7:0]  d_mode;
  logic [15:0] d_cnt;
  logic        d_ev;
  logic [1:0]  d_idx;

  edge_event_capture #(.N(4), .FILT_LEN(1), .CW(2), .INIT(0)) u_a (
    .clk(clk), .rst(rst), .in(a_in), .mode(a_mode), .clr(a_clr),
    .filt(a_filt), .pulse(a_pulse), .pulse_dir(a_dir), .sticky(a_sticky),
    .cnt(a_cnt), .evt_valid(a_ev), .evt_idx(a_idx)
  );

  edge_event_capture #(.N(4), .FILT_LEN(3), .CW(8), .INIT(0)) u_b (
    .clk(clk), .rst(rst), .in(b_in), .mode(b_mode), .clr(b_clr),
    .filt(b_filt), .pulse(b_pulse), .pulse_dir(b_dir), .sticky(b_sticky),
    .cnt(b_cnt), .evt_valid(b_ev), .evt_idx(b_idx)
  );

  edge_event_capture #(.N(4), .FILT_LEN(4), .CW(4), .INIT(0)) u_c (
    .clk(clk), .rst(c_rst), .in(c_in), .mode(c_mode), .clr(c_clr),
    .filt(c_filt), .pulse(c_pulse), .pulse_dir(c_dir), .sticky(c_sticky),
    .cnt(c_cnt), .evt_valid(c_ev), .evt_idx(c_idx)
  );

  edge_event_capture #(.N(4), .FILT_LEN(2), .CW(4), .INIT(1)) u_d (
    .clk(clk), .rst(rst), .in(d_in), .mode(d_mode), .clr(d_clr),
    .filt(d_filt), .pulse(d_pulse), .pulse_dir(d_dir), .sticky(d_sticky),
    .cnt(d_cnt), .evt_valid(d_ev), .evt_idx(d_idx)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1ns later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_cnt [5];
  logic       exp_dir [5];

  initial begin
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    exp_dir = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; c_rst = 1'b1;
    a_in = '0; a_mode = '0; a_clr = '0;
    b_in = '0; b_mode = '0; b_clr = '0;
    c_in = '0; c_mode = '0; c_clr = '0;
    d_in = 4'hF; d_mode = '0; d_clr = '0;
    step(2);

    // reset state
    check("rst_a_filt", a_filt, 4'h0);
    check("rst_a_pulse", a_pulse, 4'h0);
    check("rst_a_cnt", a_cnt, 8'h00);
    check("rst_a_sticky", a_sticky, 4'h0);
    check("rst_a_ev_idx", {a_ev, a_idx}, 3'b000);
    check("rst_d_filt_init1", d_filt, 4'hF);
    rst = 1'b0; c_rst = 1'b0;
    step(1);

    // a: single rising event on ch2, FILT_LEN=1
    a_mode = 8'b0101_0101;
    a_in[2] = 1'b1;
    step(1);
    check("a_rise_pulse", a_pulse, 4'b0100);
    check("a_rise_dir2", a_dir[2], 1'b1);
    check("a_rise_cnt2", a_cnt[5:4], 2'd1);
    check("a_rise_sticky2", a_sticky[2], 1'b1);
    check("a_rise_ev_idx", {a_ev, a_idx}, 3'b110);
    step(1);
    check("a_rise_pulse_gone", a_pulse, 4'b0000);
    check("a_rise_ev_idx_gone", {a_ev, a_idx}, 3'b000);

    // a: ch1 both edges, consecutive toggles, CW=2 saturation
    a_mode[3:2] = 2'b11;
    for (int t = 0; t < 5; t++) begin
      a_in[1] = ~a_in[1];
      step(1);
      check($sformatf("a_sat_pulse_%0d", t), a_pulse, 4'b0010);
      check($sformatf("a_sat_dir_%0d", t), a_dir[1], exp_dir[t]);
      check($sformatf("a_sat_cnt_%0d", t), a_cnt[3:2], exp_cnt[t]);
    end
    // 6th edge together with clr: event wins over the cleared value
    a_in[1] = 1'b0;
    a_clr = 4'b0010;
    step(1);
    a_clr = 4'b0000;
    check("a_clr_evt_cnt1", a_cnt[3:2], 2'd1);
    check("a_clr_evt_sticky1", a_sticky[1], 1'b1);
    check("a_clr_evt_dir1", a_dir[1], 1'b0);
    // clr alone
    a_clr = 4'b0010;
    step(1);
    a_clr = 4'b0000;
    check("a_clr_only_cnt1", a_cnt[3:2], 2'd0);
    check("a_clr_only_sticky", a_sticky, 4'b0100);
    check("a_clr_only_cnt2", a_cnt[5:4], 2'd1);

    // a: simultaneous rises on ch1 and ch3, encoder priority
    a_mode = 8'b0101_0101;
    a_in = 4'b1110;
    step(1);
    check("a_dual_pulse", a_pulse, 4'b1010);
    check("a_dual_ev_idx", {a_ev, a_idx}, 3'b101);
    a_in = 4'b0100;
    step(1);
    check("a_fall_ignored", a_pulse, 4'b0000);
    a_mode[7:6] = 2'b00;
    a_in = 4'b1110;
    step(1);
    check("a_off_pulse", a_pulse, 4'b0010);
    check("a_off_ev_idx", {a_ev, a_idx}, 3'b101);
    check("a_off_cnt3", a_cnt[7:6], 2'd1);
    check("a_off_cnt1", a_cnt[3:2], 2'd2);
    check("a_off_filt", a_filt, 4'b1110);

    // b: FILT_LEN=3 glitch rejection
    b_mode = 8'b0000_0011;
    b_in[0] = 1'b1;
    step(2);
    check("b_glitch_filt", b_filt, 4'h0);
    check("b_glitch_pulse", b_pulse, 4'h0);
    b_in[0] = 1'b0;
    step(1);
    check("b_glitch_end_filt", b_filt, 4'h0);
    b_in[0] = 1'b1;
    step(2);
    check("b_run2_filt", b_filt, 4'h0);
    check("b_run2_pulse", b_pulse, 4'h0);
    step(1);
    check("b_rise_filt", b_filt, 4'h1);
    check("b_rise_pulse", b_pulse, 4'h1);
    check("b_rise_dir", b_dir[0], 1'b1);
    check("b_rise_cnt0", b_cnt[7:0], 8'd1);
    step(1);
    check("b_rise_pulse_gone", b_pulse, 4'h0);
    b_in[0] = 1'b0;
    step(2);
    check("b_fall_wait", b_pulse, 4'h0);
    step(1);
    check("b_fall_pulse", b_pulse, 4'h1);
    check("b_fall_dir", b_dir[0], 1'b0);
    check("b_fall_cnt0", b_cnt[7:0], 8'd2);
    check("b_fall_filt", b_filt, 4'h0);

    // c: reset mid-filter discards the partial run
    c_mode = 8'b0000_0001;
    c_in[0] = 1'b1;
    step(2);
    c_rst = 1'b1;
    step(1);
    c_rst = 1'b0;
    check("c_rst_filt", c_filt, 4'h0);
    step(3);
    check("c_post3_filt", c_filt, 4'h0);
    check("c_post3_pulse", c_pulse, 4'h0);
    step(1);
    check("c_post4_filt", c_filt, 4'h1);
    check("c_post4_pulse", c_pulse, 4'h1);
    check("c_post4_cnt0", c_cnt[3:0], 4'd1);

    // d: INIT=1, falling event on ch0 with mode 10
    d_mode = 8'b0000_0010;
    d_in[0] = 1'b0;
    step(1);
    check("d_wait_filt", d_filt, 4'hF);
    check("d_wait_pulse", d_pulse, 4'h0);
    step(1);
    check("d_fall_filt", d_filt, 4'hE);
    check("d_fall_pulse", d_pulse, 4'h1);
    check("d_fall_dir", d_dir[0], 1'b0);
    check("d_fall_ev_idx", {d_ev, d_idx}, 3'b100);
    check("d_fall_cnt0", d_cnt[3:0], 4'd1);
    d_in[0] = 1'b1;
    step(2);
    check("d_rise_ignored_filt", d_filt, 4'hF);
    check("d_rise_ignored_pulse", d_pulse, 4'h0);
    check("d_rise_ignored_cnt0", d_cnt[3:0], 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/edge_event_capture.md
Name: edge_event_capture

Overview:
- Multi-channel, parametrised successor to the single-bit edge detector used in msdsl emulation models.
- Each channel passes its input through a glitch filter, then detects edges per a runtime-selectable mode (off, rising, falling, both).
- Per channel it emits a registered one-cycle pulse, a sticky flag and a saturating event counter.
- A lowest-index event encoder summarises all channels for downstream sequencers.

Parameters:
N, 4, number of channels (>=1)
FILT_LEN, 1, consecutive clock edges a changed input must persist before the filtered level flips (>=1; 1 = plain register)
CW, 8, per-channel event counter width (>=1)
INIT, 0, filtered-level reset value, applied to all channels (0 or 1)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-high
in  in  N  raw channel inputs, already synchronous to clk
mode  in  2N  per channel bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
clr  in  N  per-channel synchronous clear of sticky and cnt
filt  out  N  filtered level per channel
pulse  out  N  one-cycle event strobe per channel
pulse_dir  out  N  polarity of the most recent pulse (1 rising, 0 falling); holds between pulses
sticky  out  N  set by pulse, cleared by clr
cnt  out  N*CW  saturating event counters, channel i at [i*CW +: CW]
evt_valid  out  1  OR of pulse
evt_idx  out  IW  lowest i with pulse[i]=1, where IW = max(1, clog2(N)); 0 when evt_valid=0

Behaviour:
- Reset (rst=1 at posedge): filt=INIT for all channels; filter run counters=0; pulse=0; pulse_dir=0; sticky=0; cnt=0; evt_valid=0; evt_idx=0. Reset mid-filter discards any partial run. rst overrides clr and any event.
- Filter, per channel, run counter width clog2(FILT_LEN+1):
  - When in[i]==filt[i], the run counter is 0.
  - When in[i]!=filt[i], the run counter increments each edge.
  - On the edge where the counter would reach FILT_LEN, filt[i] <= in[i] and the counter returns to 0.
  - A mismatch shorter than FILT_LEN edges never changes filt.
  - FILT_LEN=1: filt[i] <= in[i] every edge.
- Edge event, on the edge where filt[i] flips:
  - rise = flip to 1; fall = flip to 0.
  - Event is enabled if (rise && mode[2i]) || (fall && mode[2i+1]). Mode is sampled at that same edge.
  - An event flipping filt while mode=00 is lost, not deferred.
- Pulse and direction:
  - pulse[i] is registered and high for exactly one cycle, aligned with the first cycle filt shows the new level.
  - Latency: a clean input change present before edge k produces pulse at edge k+FILT_LEN-1.
  - pulse_dir[i] updates only with an event.
  - Back-to-back events on consecutive edges (possible only when FILT_LEN=1) give consecutive pulse cycles.
- Sticky and counter, per channel:
  - On event: sticky <= 1; cnt <= cnt+1, saturating at 2^CW-1 (no wrap).
  - clr[i] alone: sticky <= 0, cnt <= 0.
  - clr[i] and event at the same edge: the event wins over the prior value, giving sticky=1 and cnt=1.
- Encoder: evt_valid and evt_idx are combinational from pulse, so they are cycle-aligned with pulse. Lowest index has priority.
- Channels are fully independent; no shared state except the encoder.

Test Plan:
- N=4, FILT_LEN=1, mode=all 01; raise in[2] before edge 5 -> pulse[2]=1 in the cycle after edge 5 only, pulse_dir[2]=1, cnt2=1, sticky[2]=1, evt_valid=1, evt_idx=2.
- FILT_LEN=3, ch0 mode 11; in[0] high for 2 edges, then low -> no filt change and no pulse; then high for 3 edges -> filt[0]=1 and pulse[0] at the 3rd edge; then low for 3 edges -> pulse with pulse_dir[0]=0, cnt0=2.
- CW=2, ch1 mode 11, toggle in[1] 5 times -> cnt1 sequence 1,2,3,3,3 (saturates at 3); then assert clr[1] together with a 6th edge -> cnt1=1, sticky[1]=1.
- Rising edges on ch1 and ch3 at the same edge -> pulse=4'b1010, evt_idx=1; ch3 mode 00 at that edge -> pulse=4'b0010, cnt3 unchanged.
- FILT_LEN=4, assert rst after 2 mismatched edges, release, hold input for 3 more edges -> no flip; flip occurs on the 4th post-reset mismatch edge, filt first returning to INIT=0 at reset.
- INIT=1 with ch0 in=0 after reset, mode 10 -> falling pulse after FILT_LEN edges, pulse_dir[0]=0, evt_idx=0.
